reg_file: RTL
=============

// Module: reg_file
// PURPOSE
//   Architectural integer register file of the single-cycle RV32 core.
//   - Two combinational read ports feed ALU operand muxes.
//   - One synchronous write port is driven by the writeback-select mux (ALU result vs load data).
//   - Register x0 is hardwired to zero.
// PARAMETERS
//   DATA_W   32   register width in bits
//   ADDR_W   5    register index width; depth = 2**ADDR_W (32 entries)
// PORTS
//   clk       in   1        core clock; all writes on rising edge
//   rst_n     in   1        asynchronous active-low reset
//   rs1_addr  in   ADDR_W   read port 1 index
//   rs1_data  out  DATA_W   read port 1 data
//   rs2_addr  in   ADDR_W   read port 2 index
//   rs2_data  out  DATA_W   read port 2 data
//   rd_we     in   1        write enable (RegWrite from control unit)
//   rd_addr   in   ADDR_W   write index
//   rd_data   in   DATA_W   write data (writeback mux output)
// BEHAVIOUR
//   - Reset: rst_n low clears all 2**ADDR_W entries to 0 immediately, with no clock required.
//   - Reset outputs: rs1_data and rs2_data read 0 while reset is held.
//   - Reset release: first write may occur on the first rising clk after rst_n goes high.
//   - Write: on rising clk, if rd_we=1 and rd_addr!=0, then mem[rd_addr] <= rd_data.
//   - Write latency: the new value is architecturally visible after the edge.
//   - x0 writes: rd_we with rd_addr=0 is silently dropped, and entry 0 is never written.
//   - rd_we=0: no entry changes, whatever rd_addr and rd_data hold.
//   - Read: rsN_data = (rsN_addr==0) ? 0 : mem[rsN_addr].
//     Reads are purely combinational, with zero latency and no clock dependency.
//   - Read ports are independent: both may address the same entry.
//   - Read ports may address the entry being written. Without bypass, a read in the
//     write cycle returns the OLD value; the new value appears after the edge.
//   - Reset mid-operation: an asynchronous assert during a pending write discards the
//     write; all entries read 0.
//   - Address range is the full 2**ADDR_W, so no out-of-range case exists.
//   - Widths: no truncation or extension; rd_data is stored verbatim.
//   - Storage: the storage array is an implementation choice (flops required for the
//     asynchronous clear), but storage must not be inferred as block RAM.
// CONFIGURATION
//   REG_FILE_BYPASS_EN
//     - Defined: write-through forwarding on each read port. If rd_we=1, rd_addr!=0 and
//       rsN_addr==rd_addr, then rsN_data = rd_data in the same cycle, before the edge.
//     - Defined: the x0 rule still wins, so rsN_addr=0 always reads 0.
//     - Defined: bypass is gated by rst_n; during reset the outputs still read 0.
//     - Undefined: no forwarding; the old-value read semantics above apply.
//     - The port list is identical in both builds.
// TESTING
//   1. Reset: hold rst_n=0 with no clk edges; sweep rs1_addr/rs2_addr over 0..31
//      -> both read 0x00000000.
//   2. Write/read: write x5=0xDEADBEEF, then x31=0x12345678; set rs1=5, rs2=31
//      -> 0xDEADBEEF and 0x12345678.
//   3. x0 protection: rd_we=1, rd_addr=0, rd_data=0xFFFFFFFF, clock; rs1=0
//      -> 0x00000000.
//   4. Write gating: x7=0xAAAAAAAA; then rd_we=0, rd_addr=7, rd_data=0x55555555, clock
//      -> x7 still 0xAAAAAAAA.
//   5. Same-cycle read: x9=0x11111111; then rd_we=1, rd_addr=9, rd_data=0x22222222;
//      rs1=9 and rs2=9 sampled before the edge.
//      -> 0x11111111, or 0x22222222 with REG_FILE_BYPASS_EN. After the edge both builds
//      -> 0x22222222.
//   6. Async reset mid-run: fill x1..x31 with index*0x01010101; pulse rst_n low for
//      3 ns between edges -> all reads 0 immediately, and they stay 0 after release.

Source files
------------

// File: rtl/reg_file.sv
// Integer register file for the single-cycle RV32 core.
// Two combinational read ports and one synchronous write port. Register x0
// always reads zero. All entries are cleared asynchronously by rst_n.
// Optional feature: define REG_FILE_BYPASS_EN so that a same-cycle write is
// forwarded to any read port that addresses the entry being written.

module reg_file_rd_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]                addr,
`ifdef REG_FILE_BYPASS_EN
  input  logic                             rst_n,
  input  logic                             rd_we,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic [DATA_W-1:0]                rd_data,
`endif
  output logic [DATA_W-1:0]                data
);

  // x0 reads zero; other indices read storage, or the in-flight write when forwarding
  always_comb begin
    data = '0;
    if (addr != '0) begin
      data = mem[addr];
`ifdef REG_FILE_BYPASS_EN
      // Forwarding is suppressed in reset so the outputs stay zero
      if (rst_n && rd_we && (rd_addr != '0) && (addr == rd_addr))
        data = rd_data;
`endif
    end
  end

endmodule

module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [DATA_W-1:0] rs1_data,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              rd_we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH     = 2**ADDR_W;
  localparam int NUM_PORTS = 2;

  // Flop storage: the asynchronous clear keeps it out of block RAM. Entry 0 is
  // only ever cleared, so it reduces to a constant.
  logic [DEPTH-1:0][DATA_W-1:0]     mem;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rs_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rs_data;

  assign rs_addr  = {rs2_addr, rs1_addr};
  assign rs1_data = rs_data[0];
  assign rs2_data = rs_data[1];

  // Async clear of every entry; write on rising edge, x0 writes dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mem <= '0;
    else if (rd_we && (rd_addr != '0))
      mem[rd_addr] <= rd_data;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    reg_file_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port (
      .mem     (mem),
      .addr    (rs_addr[p]),
`ifdef REG_FILE_BYPASS_EN
      .rst_n   (rst_n),
      .rd_we   (rd_we),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
`endif
      .data    (rs_data[p])
    );
  end

endmodule
